// File: rtl/debug_unit.sv
// Host debug controller: loads instruction memory from UART bytes,
// runs or steps the pipeline, then streams PC/registers/memory back.
module debug_unit #(
  parameter int INST_SZ = 32,
  parameter int PC_SZ = 32,
  parameter int REG_SZ = 5,
  parameter int BYTE_SZ = 8,
  parameter int MEM_SZ = 10,
  parameter logic [INST_SZ-1:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [PC_SZ-1:0]   i_pc,
  input  logic [INST_SZ-1:0] i_reg,
  input  logic [INST_SZ-1:0] i_mem,
  input  logic               i_halt,
  output logic [BYTE_SZ-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_write,
  output logic [INST_SZ-1:0] o_instruction,
  output logic               o_enable,
  output logic [REG_SZ-1:0]  o_debug_addr,
  output logic               o_busy
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    WRITE,
    RUN,
    STEP,
    DUMP_SET,
    DUMP_LATCH,
    DUMP_SEND,
    DUMP_WAIT
  } state_t;

  localparam logic [BYTE_SZ-1:0] CMD_L = BYTE_SZ'('h4C);
  localparam logic [BYTE_SZ-1:0] CMD_C = BYTE_SZ'('h43);
  localparam logic [BYTE_SZ-1:0] CMD_S = BYTE_SZ'('h53);
  localparam logic [6:0] LAST_WORD = 7'd64;
  localparam logic [6:0] REG_END = 7'd32;
  localparam logic [MEM_SZ:0] LOAD_LAST = {1'b0, {MEM_SZ{1'b1}}};

  state_t state;
  state_t next;

  logic [INST_SZ-1:0] shift;
  logic [INST_SZ-1:0] word;
  logic [1:0] byte_cnt;
  logic [6:0] word_idx;
  logic [MEM_SZ:0] load_cnt;
  logic [INST_SZ-1:0] sel;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else state <= next;
  end

  always_comb begin
    next = state;
    o_write = 1'b0;
    o_enable = 1'b0;
    o_tx_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_rx_done) begin
          unique case (1'b1)
            (i_rx_data == CMD_L): next = LOAD;
            (i_rx_data == CMD_C): next = RUN;
            (i_rx_data == CMD_S): next = STEP;
            default: next = IDLE;
          endcase
        end
      end
      LOAD: begin
        if (i_rx_done && byte_cnt == 2'd3) next = WRITE;
      end
      WRITE: begin
        o_write = 1'b1;
        if (shift == HALT_INST || load_cnt == LOAD_LAST)
          next = IDLE;
        else
          next = LOAD;
      end
      RUN: begin
        if (i_halt) next = DUMP_SET;
        else o_enable = 1'b1;
      end
      STEP: begin
        o_enable = !i_halt;
        next = DUMP_SET;
      end
      DUMP_SET: next = DUMP_LATCH;
      DUMP_LATCH: next = DUMP_SEND;
      DUMP_SEND: begin
        o_tx_start = 1'b1;
        next = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        if (i_tx_done) begin
          if (byte_cnt != 2'd3) next = DUMP_SEND;
          else if (word_idx == LAST_WORD) next = IDLE;
          else next = DUMP_SET;
        end
      end
      default: next = IDLE;
    endcase
  end

  // word 0 is the PC, then 32 registers, then 32 memory words
  always_comb begin
    sel = i_mem;
    if (word_idx == '0) sel = INST_SZ'(i_pc);
    else if (word_idx <= REG_END) sel = i_reg;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      shift <= '0;
      word <= '0;
      byte_cnt <= '0;
      word_idx <= '0;
      load_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          byte_cnt <= '0;
          word_idx <= '0;
          if (i_rx_done && i_rx_data == CMD_L)
            load_cnt <= '0;
        end
        LOAD: begin
          if (i_rx_done) begin
            shift <= {shift[INST_SZ-BYTE_SZ-1:0], i_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WRITE: load_cnt <= load_cnt + 1'b1;
        DUMP_LATCH: word <= sel;
        DUMP_WAIT: begin
          if (i_tx_done) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3 && word_idx != LAST_WORD)
              word_idx <= word_idx + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_instruction = shift;
  assign o_busy = (state != IDLE);
  assign o_debug_addr =
    (word_idx == '0) ? '0 : REG_SZ'(word_idx - 7'd1);
  // MSB-first: byte 0 takes the top byte of the latched word
  assign o_tx_data =
    BYTE_SZ'(word >> {~byte_cnt, 3'b000});

endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: emulated pipeline and UART transmitter,
// table vectors, random dumps/loads against a queue-based model.
module tb_debug_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [7:0] rx_data;
  logic rx_done;
  logic tx_done;
  logic [31:0] pc_in;
  logic [31:0] reg_in;
  logic [31:0] mem_in;
  logic halt;
  logic [7:0] tx_data;
  logic tx_start;
  logic wr;
  logic [31:0] instr;
  logic enable;
  logic [4:0] dbg_addr;
  logic busy;

  logic [31:0] regs [32];
  logic [31:0] mems [32];

  assign reg_in = regs[dbg_addr];
  assign mem_in = mems[dbg_addr];

  debug_unit dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_rx_data(rx_data),
    .i_rx_done(rx_done),
    .i_tx_done(tx_done),
    .i_pc(pc_in),
    .i_reg(reg_in),
    .i_mem(mem_in),
    .i_halt(halt),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .o_write(wr),
    .o_instruction(instr),
    .o_enable(enable),
    .o_debug_addr(dbg_addr),
    .o_busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_cnt = 0;
  int viol = 0;
  int last_rx = 0;
  logic prev_tx = 1'b0;
  logic prev_wr = 1'b0;
  logic [7:0] tx_q [$];
  int tx_cyc_q [$];
  logic [31:0] wr_q [$];
  int wr_cyc_q [$];
  logic [31:0] ld_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (enable) en_cnt++;
    if (tx_start) begin
      tx_q.push_back(tx_data);
      tx_cyc_q.push_back(cyc);
    end
    if (wr) begin
      wr_q.push_back(instr);
      wr_cyc_q.push_back(cyc);
    end
    if ((tx_start && prev_tx) || (wr && prev_wr)) viol++;
    prev_tx = tx_start;
    prev_wr = wr;
  end

  // UART transmitter: acknowledges each byte 1..4 cycles later
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        repeat ($urandom_range(0, 3) + 1) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " busy"}, 64'(busy), 0);
    chk({tag, " tx_start"}, 64'(tx_start), 0);
    chk({tag, " write"}, 64'(wr), 0);
    chk({tag, " enable"}, 64'(enable), 0);
    chk({tag, " tx_data"}, 64'(tx_data), 0);
    chk({tag, " instr"}, 64'(instr), 0);
    chk({tag, " addr"}, 64'(dbg_addr), 0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    bit halt_pre;
    int n;
    int exp_en;
    int exp_lat;
    bit noise;
    int exp_bytes;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int a;
    int t;
    int eb;
    int tb0;
    int bad;
    logic [31:0] wd;
    logic [7:0] exp_q [$];
    pc_in = $urandom;
    for (int i = 0; i < 32; i++) begin
      regs[i] = $urandom;
      mems[i] = $urandom;
    end
    for (int w = 0; w < 65; w++) begin
      if (w == 0) wd = pc_in;
      else if (w <= 32) wd = regs[w-1];
      else wd = mems[w-33];
      for (int k = 0; k < 4; k++)
        exp_q.push_back(8'((wd >> (24 - 8*k)) & 32'hFF));
    end
    halt = v.halt_pre;
    eb = en_cnt;
    tb0 = tx_q.size();
    @(posedge clk);
    #1 rx_data = v.cmd;
    rx_done = 1'b1;
    a = cyc;
    @(posedge clk);
    #1 rx_done = 1'b0;
    if (v.cmd == 8'h43 && !v.halt_pre) begin
      t = 0;
      while ((en_cnt - eb) < v.n && t < 500) begin
        @(posedge clk);
        #1 t++;
      end
      halt = 1'b1;
      chk({tag, " run_wait"}, 64'(t < 500), 1);
    end
    t = 0;
    while (busy && t < 5000) begin
      @(posedge clk);
      #1 rx_done = 1'b0;
      if (v.noise && busy && (t % 40 == 20)) begin
        rx_data = 8'h4C;
        rx_done = 1'b1;
      end
      t++;
    end
    rx_done = 1'b0;
    chk({tag, " dump_end"}, 64'(t < 5000), 1);
    repeat (6) @(posedge clk);
    #1;
    chk({tag, " idle"}, 64'(busy), 0);
    chk({tag, " enables"}, 64'(en_cnt - eb), 64'(v.exp_en));
    chk({tag, " bytes"}, 64'(tx_q.size() - tb0), 64'(v.exp_bytes));
    if (v.exp_bytes > 0) begin
      bad = 0;
      for (int i = 0; i < v.exp_bytes; i++)
        if (tb0 + i >= tx_q.size() || tx_q[tb0+i] !== exp_q[i])
          bad++;
      chk({tag, " data_bad"}, 64'(bad), 0);
      chk({tag, " latency"},
          (tx_q.size() > tb0) ? 64'(tx_cyc_q[tb0] - a) : '1,
          64'(v.exp_lat));
    end
    halt = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_done = 1'b1;
    last_rx = cyc;
    @(posedge clk);
    #1 rx_done = 1'b0;
  endtask

  // sends ld_q; the first exp_n words must come back as writes
  task automatic load_words(input int exp_n, input string tag);
    int wb;
    int t;
    int bad;
    int r4;
    wb = wr_q.size();
    r4 = 0;
    send_byte(8'h4C);
    foreach (ld_q[i]) begin
      for (int k = 0; k < 4; k++)
        send_byte(8'((ld_q[i] >> (24 - 8*k)) & 32'hFF));
      if (i == 0) r4 = last_rx;
    end
    t = 0;
    while (busy && t < 50) begin
      @(posedge clk);
      #1 t++;
    end
    chk({tag, " idle"}, 64'(busy), 0);
    chk({tag, " writes"}, 64'(wr_q.size() - wb), 64'(exp_n));
    bad = 0;
    for (int i = 0; i < exp_n; i++)
      if (wb + i >= wr_q.size() || wr_q[wb+i] !== ld_q[i]) bad++;
    chk({tag, " wdata_bad"}, 64'(bad), 0);
    chk({tag, " wlat"},
        (wr_q.size() > wb) ? 64'(wr_cyc_q[wb] - r4) : '1, 1);
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    int t;
    int tb0;
    int n;
    rst_n = 1'b0;
    rx_done = 1'b0;
    rx_data = '0;
    halt = 1'b0;
    pc_in = '0;
    for (int i = 0; i < 32; i++) begin
      regs[i] = '0;
      mems[i] = '0;
    end

    tbl[0] = '{8'h43, 1'b0, 10, 10, 14, 1'b0, 260};
    tbl[1] = '{8'h53, 1'b0, 0, 1, 4, 1'b0, 260};
    tbl[2] = '{8'h53, 1'b1, 0, 0, 4, 1'b0, 260};
    tbl[3] = '{8'h43, 1'b1, 0, 0, 4, 1'b0, 260};
    tbl[4] = '{8'h58, 1'b0, 0, 0, 0, 1'b0, 0};
    tbl[5] = '{8'h43, 1'b0, 3, 3, 7, 1'b1, 260};
    tbl[6] = '{8'h53, 1'b0, 0, 1, 4, 1'b1, 260};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(1, 15);
      rv.cmd = ($urandom_range(0, 1) == 1) ? 8'h43 : 8'h53;
      rv.halt_pre = 1'b0;
      rv.n = n;
      rv.exp_en = (rv.cmd == 8'h43) ? n : 1;
      rv.exp_lat = (rv.cmd == 8'h43) ? n + 4 : 4;
      rv.noise = 1'($urandom_range(0, 1));
      rv.exp_bytes = 260;
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    ld_q = {32'h2001_0005, 32'hFFFF_FFFF};
    load_words(2, "load_fixed");

    ld_q.delete();
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++)
      ld_q.push_back($urandom & 32'h7FFF_FFFF);
    ld_q.push_back(32'hFFFF_FFFF);
    load_words(n + 1, "load_rnd");

    ld_q.delete();
    for (int i = 0; i < 1024; i++)
      ld_q.push_back(32'h1000_0000 + i);
    load_words(1024, "load_full");

    tb0 = tx_q.size();
    halt = 1'b0;
    @(posedge clk);
    #1 rx_data = 8'h53;
    rx_done = 1'b1;
    @(posedge clk);
    #1 rx_done = 1'b0;
    t = 0;
    while (tx_q.size() - tb0 < 10 && t < 2000) begin
      @(posedge clk);
      #1 t++;
    end
    chk("mid_dump_reach", 64'(t < 2000), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_quiet("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    run_vec(tbl[1], "after_reset");

    chk("back_to_back", 64'(viol), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_unit.md
# debug_unit

Host-side debug controller sitting directly upstream of the five-stage MIPS pipeline: it drives the pipeline's i_write, i_enable, i_instruction and i_debug_addr inputs and consumes o_pc, o_reg, o_mem and o_halt. It receives command and program bytes from a UART receiver, loads the instruction memory, runs the pipeline continuously or one cycle at a time, and streams a state dump (PC, 32 registers, 32 data words) back through a UART transmitter.

## Interface
- INST_SZ, 32, instruction / data word width
- PC_SZ, 32, PC width
- REG_SZ, 5, debug address width (register/memory index)
- BYTE_SZ, 8, UART byte width
- MEM_SZ, 10, log2 of instruction memory depth in words
- HALT_INST, 32'hFFFF_FFFF, instruction word that terminates a load

- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  BYTE_SZ  received byte
- i_rx_done  in  1  one-cycle strobe, i_rx_data valid
- i_tx_done  in  1  one-cycle strobe, transmitter finished previous byte
- i_pc  in  PC_SZ  pipeline PC (o_pc)
- i_reg  in  INST_SZ  pipeline register read at o_debug_addr
- i_mem  in  INST_SZ  pipeline data-memory word at o_debug_addr
- i_halt  in  1  pipeline halt reached
- o_tx_data  out  BYTE_SZ  byte to transmit
- o_tx_start  out  1  one-cycle strobe, start transmission
- o_write  out  1  one-cycle instruction-memory write strobe
- o_instruction  out  INST_SZ  assembled instruction
- o_enable  out  1  pipeline advance enable
- o_debug_addr  out  REG_SZ  debug read index
- o_busy  out  1  high in every state except IDLE

## Operation
- Commands (ASCII, received in IDLE): 'L' load, 'C' continuous, 'S' step. Any other byte ignored, stay IDLE.
- States: IDLE, LOAD, WRITE, RUN, STEP, DUMP_SET, DUMP_LATCH, DUMP_SEND, DUMP_WAIT.
- LOAD: collect 4 bytes MSB first into shift register; on 4th byte go WRITE. WRITE: o_write=1 one cycle with o_instruction; word counter +1. If word == HALT_INST or counter reaches 2^MEM_SZ -> IDLE, else LOAD.
- RUN: o_enable=1 each cycle while i_halt=0; on first cycle i_halt=1, o_enable=0 and go DUMP_SET.
- STEP: o_enable=1 for exactly one cycle, then DUMP_SET. If i_halt already 1, o_enable stays 0 (dump only).
- Halt is sticky in the pipeline; 'C'/'S' after halt produce a dump with no enable pulse.
- Dump sequence: word 0 = i_pc; words 1..32 = i_reg for index 0..31; words 33..64 = i_mem for index 0..31. Total 65 words, 260 bytes.
- DUMP_SET: drive o_debug_addr = index; DUMP_LATCH: latch selected word (one-cycle read settle). DUMP_SEND: o_tx_start=1 with o_tx_data = current byte, MSB first. DUMP_WAIT: hold until i_tx_done, then next byte / next word; after byte 260 -> IDLE.
- i_rx_done outside IDLE/LOAD is ignored (no command queueing).
- Counters: byte index 2 bits wraps 3->0; word index 7 bits (0..64); load counter MEM_SZ+1 bits.

## Timing
- Reset (any time, async): state IDLE, all outputs 0, all counters and shift register 0; in-flight load/run/dump aborted.
- Command byte accepted on the i_rx_done cycle; new state effective next edge.
- Load latency: o_write asserted the cycle after the 4th byte's i_rx_done.
- o_enable registered: asserted the cycle after 'C'/'S' accepted.
- Dump: first o_tx_start 3 cycles after halt detected / step pulse (SET, LATCH, SEND). Each subsequent byte: o_tx_start the cycle after i_tx_done; new word adds SET+LATCH (2 cycles).
- i_tx_done and i_rx_done on the same cycle: tx handled, rx dropped.
- o_tx_start, o_write never high for more than one consecutive cycle.

## Test plan
- Reset: drive i_reset=0 mid-dump -> all outputs 0, state IDLE, next 'S' starts dump from word 0.
- Load: 'L', bytes 20 01 00 05, then FF FF FF FF -> o_write pulse with 0x20010005, second pulse with 0xFFFFFFFF, then o_busy=0.
- Continuous: 'C' with i_halt rising after 10 cycles -> o_enable high exactly 10 cycles, then 260 tx bytes; first 4 = i_pc MSB first.
- Step: 'S' -> o_enable high exactly 1 cycle; o_debug_addr sweeps 0..31 twice; 260 o_tx_start pulses, each after i_tx_done.
- Step after halt: i_halt=1, 'S' -> o_enable never high, full 260-byte dump.
- Ignored input: byte 'X' in IDLE and rx bytes during dump -> no state change, dump byte count still 260.
